turn_request_ctrl: RTL
======================

# turn_request_ctrl

Front-end conditioner for the tail-light sequencer. It synchronizes and debounces the raw left/right turn-lever and hazard-button inputs, and arbitrates them in a state machine. It drives the sequencer's single-cycle-clean `turn_l`/`turn_r`/`hazard` request levels. It watches the sequencer's 2-bit phase counter so that a released turn request always finishes its current light sequence instead of truncating mid-sweep.

## Interface
- `DEB_CYCLES`, default 4: consecutive synchronized-stable cycles required before a debounced level changes; legal range 1..255.
- `clk`  in  1  system clock; all registers update on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `sw_left`  in  1  raw left lever level, asynchronous, may bounce.
- `sw_right`  in  1  raw right lever level, asynchronous, may bounce.
- `btn_haz`  in  1  raw momentary hazard button, asynchronous, may bounce.
- `seq_q`  in  2  sequencer phase counter (0→1→2→3→0), same clock source.
- `turn_l`  out  1  left turn request to sequencer.
- `turn_r`  out  1  right turn request to sequencer.
- `hazard`  out  1  hazard request to sequencer.

## Operation
- **Synchronizer:** 2-flop synchronizer on each of `sw_left`, `sw_right`, `btn_haz`, giving synchronized levels `s_*`.
- **Debounce:** one counter and one debounced level `d_*` per input.
  - The counter clears whenever `s == d`.
  - It increments while `s != d`.
  - On the cycle the count would reach `DEB_CYCLES`, `d <= s` and the counter clears.
- **Hazard toggle:** a rising edge of `d_haz` (registered previous value 0, current 1) produces a one-cycle `haz_tog`.
- **Frame wrap:** `wrap` is asserted when the registered previous `seq_q` is 3 and the current `seq_q` is 0.
- **States:** IDLE, LEFT, LEFT_END, RIGHT, RIGHT_END, HAZARD.
- **Transitions** (`haz_tog` has highest priority in every state):
  - any non-HAZARD state with `haz_tog` → HAZARD.
  - HAZARD with `haz_tog` → IDLE. Re-arbitration happens from IDLE on the next cycle.
  - IDLE: `d_left & !d_right` → LEFT; `d_right & !d_left` → RIGHT; both or neither → IDLE.
  - LEFT: `!d_left | d_right` → LEFT_END; else stay. RIGHT is symmetric.
  - LEFT_END: `d_left & !d_right` → LEFT; else `wrap` → IDLE; else stay. RIGHT_END is symmetric.
- **Outputs:** decoded directly from the state register, with no combinational input-to-output path.
  - `turn_l` = LEFT or LEFT_END.
  - `turn_r` = RIGHT or RIGHT_END.
  - `hazard` = HAZARD.
- **Mutual exclusion:** at most one output is high in any cycle.
- **Direction reversal:** an opposite lever while in a *_END state waits for `wrap`, goes to IDLE, then enters the new direction one cycle later.

## Timing
- **Reset:** asynchronous reset clears all synchronizer flops, debounce counters, `d_*`, previous-`seq_q` (to 0) and previous-`d_haz`. The state becomes IDLE and all outputs are 0 immediately, without waiting for a clock. Reset mid-sequence discards any pending END state.
- **Lever latency:** a raw lever change stable from rising edge N produces the output change at edge N+DEB_CYCLES+2. With `DEB_CYCLES`=4 that is 7 edges counting edge N as the first.
- **Hazard latency:** the same latency as a lever, measured to the `d_haz` rising edge plus 0 cycles.
- **Glitch rejection:** a raw pulse shorter than `DEB_CYCLES` synchronized cycles never changes `d_*`.
- **End of a released turn:** the output drops on the first rising edge after `wrap` is seen. This occurs at most 4 `seq_q` steps after release.
- **Simultaneous `haz_tog` and `wrap`:** `haz_tog` wins, and the block goes to HAZARD.
- **Simultaneous valid levers:** both levers high in IDLE produce no request.
- **Held hazard button:** holding the button does not re-toggle; only a new debounced rising edge toggles.

## Test plan
- Assert `reset` mid-cycle with levers high → `turn_l`=`turn_r`=`hazard`=0 with no clock edge. After release, nothing changes until the 7th edge.
- `DEB_CYCLES`=4, hold `sw_left`=1 → `turn_l`=1 on edge 7, `turn_r`=`hazard`=0 throughout.
- A `sw_right` 3-cycle pulse and 1-cycle bounces on `btn_haz` → all outputs remain 0.
- In LEFT, release `sw_left` while `seq_q`=1 → `turn_l` stays 1 through `seq_q` 2,3. It drops on the edge after `seq_q` returns to 0.
- In LEFT, press `btn_haz` → `hazard`=1 and `turn_l`=0 on the same edge. A second press with `sw_left` still held → one IDLE cycle (all 0), then `turn_l`=1.
- Both levers high from IDLE → no output. While in LEFT_END, re-assert left only → `turn_l` stays 1 with no gap, and the block returns to LEFT.

Source files
------------

// File: rtl/turn_request_ctrl.sv
// turn_request_ctrl: synchronizes, debounces and arbitrates lever/hazard inputs into
// clean turn/hazard requests, holding a released turn until the sequencer frame wraps.
module turn_request_ctrl #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sw_left,
    input  logic       i_sw_right,
    input  logic       i_btn_haz,
    input  logic [1:0] i_seq_q,
    output logic       o_turn_l,
    output logic       o_turn_r,
    output logic       o_hazard
);
    typedef enum logic [2:0] {IDLE, LEFT, LEFT_END, RIGHT, RIGHT_END, HAZARD} state_t;

    // bit 0 = left, bit 1 = right, bit 2 = hazard
    logic [2:0]      r_sync1, r_sync2, r_deb;
    logic [2:0][7:0] r_cnt;
    logic            r_haz_prev;
    logic [1:0]      r_seq_prev;
    state_t          r_state;
    state_t          w_next;
    logic            r_turn_l, r_turn_r, r_hazard;
    logic            w_haz_tog, w_wrap, w_left, w_right;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_deb      <= '0;
            r_cnt      <= '0;
            r_haz_prev <= 1'b0;
            r_seq_prev <= 2'd0;
        end else begin
            r_sync1    <= {i_btn_haz, i_sw_right, i_sw_left};
            r_sync2    <= r_sync1;
            r_haz_prev <= r_deb[2];
            r_seq_prev <= i_seq_q;
            for (int k = 0; k < 3; k++) begin
                r_cnt[k] <= (r_sync2[k] == r_deb[k] || r_cnt[k] == 8'(DEB_CYCLES - 1)) ? 8'd0 : r_cnt[k] + 8'd1;
                if (r_sync2[k] != r_deb[k] && r_cnt[k] == 8'(DEB_CYCLES - 1))
                    r_deb[k] <= r_sync2[k];
            end
        end
    end

    assign w_haz_tog = r_deb[2] & ~r_haz_prev;
    assign w_wrap    = (r_seq_prev == 2'd3) && (i_seq_q == 2'd0);
    assign w_left    = r_deb[0] & ~r_deb[1];
    assign w_right   = r_deb[1] & ~r_deb[0];

    // END states keep the request alive until the sequencer finishes its sweep
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_left ? LEFT : w_right ? RIGHT : IDLE;
            LEFT:      w_next = w_left ? LEFT : LEFT_END;
            LEFT_END:  w_next = w_left ? LEFT : w_wrap ? IDLE : LEFT_END;
            RIGHT:     w_next = w_right ? RIGHT : RIGHT_END;
            RIGHT_END: w_next = w_right ? RIGHT : w_wrap ? IDLE : RIGHT_END;
            default:   w_next = r_state;
        endcase
        if (w_haz_tog)
            w_next = (r_state == HAZARD) ? IDLE : HAZARD;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_turn_l <= 1'b0;
            r_turn_r <= 1'b0;
            r_hazard <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_turn_l <= (w_next == LEFT) || (w_next == LEFT_END);
            r_turn_r <= (w_next == RIGHT) || (w_next == RIGHT_END);
            r_hazard <= (w_next == HAZARD);
        end
    end

    assign o_turn_l = r_turn_l;
    assign o_turn_r = r_turn_r;
    assign o_hazard = r_hazard;
endmodule
